// File: rtl/ttl_74356_if.sv
// Select-path bundle between the 74356 datapath and its select counter.
// Ports: load/scan/sel_in from master; sel_cur/wrap back from slave.
interface ttl_74356_sel_if #(
  parameter int WIDTH_SELECT = 3
);
  logic                    load;
  logic                    scan;
  logic [WIDTH_SELECT-1:0] sel_in;
  logic [WIDTH_SELECT-1:0] sel_cur;
  logic                    wrap;

  modport master (
    output load, scan, sel_in,
    input  sel_cur, wrap
  );

  modport slave (
    input  load, scan, sel_in,
    output sel_cur, wrap
  );
endinterface

// File: rtl/ttl_74356_select.sv
// Select register/counter: load, scan with wrap-around, one-cycle Wrap pulse.
// Ports: clk, clear (sync, active-high), bus (slave side of the select bundle).
module ttl_74356_select #(
  parameter int WIDTH_IN     = 8,
  parameter int WIDTH_SELECT = 3
) (
  input logic            clk,
  input logic            clear,
  ttl_74356_sel_if.slave bus
);
  logic [WIDTH_SELECT-1:0] sel_q;
  logic                    wrap_q;
  logic                    at_top;

  // Last legal channel or any out-of-range value restarts the scan at 0.
  assign at_top = 32'(sel_q) >= WIDTH_IN - 1;

  always_ff @(posedge clk) begin
    if (clear) begin
      sel_q  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      sel_q  <= bus.sel_in;
      wrap_q <= 1'b0;
    end else if (bus.scan) begin
      if (at_top) begin
        sel_q  <= '0;
        wrap_q <= 1'b1;
      end else begin
        sel_q  <= sel_q + WIDTH_SELECT'(1);
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.sel_cur = sel_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: rtl/ttl_74356.sv
// Registered multi-block multiplexer with shared scannable select register.
// Ports: Clk, Clear, Enable_bar, Select_load, Scan, Select, Data_hold, A_2D -> Y, Y_bar, Select_current, Wrap.
`ifndef ASSIGN_UNPACK
`define ASSIGN_UNPACK(DST, SRC, N, W) \
  for (genvar gi = 0; gi < (N); gi++) begin : g_unpack \
    assign DST[gi] = SRC[gi*(W) +: (W)]; \
  end
`endif

module ttl_74356 #(
  parameter int BLOCKS       = 2,
  parameter int WIDTH_IN     = 8,
  parameter int WIDTH_SELECT = $clog2(WIDTH_IN),
  parameter int DELAY_RISE   = 0,
  parameter int DELAY_FALL   = 0
) (
  input  logic                       Clk,
  input  logic                       Clear,
  input  logic [BLOCKS-1:0]          Enable_bar,
  input  logic                       Select_load,
  input  logic                       Scan,
  input  logic [WIDTH_SELECT-1:0]    Select,
  input  logic                       Data_hold,
  input  logic [WIDTH_IN*BLOCKS-1:0] A_2D,
  output logic [BLOCKS-1:0]          Y,
  output logic [BLOCKS-1:0]          Y_bar,
  output logic [WIDTH_SELECT-1:0]    Select_current,
  output logic                       Wrap
);
  logic [WIDTH_IN-1:0] a_word [BLOCKS];
  logic [WIDTH_IN-1:0] data_q [BLOCKS];
  logic [BLOCKS-1:0]   en_bar_q;
  logic [BLOCKS-1:0]   y_int;
  logic                in_range;

  // Edge delays only matter to timing models; the netlist is zero-delay.
  logic unused_delay;
  assign unused_delay = (DELAY_RISE != DELAY_FALL);

  `ASSIGN_UNPACK(a_word, A_2D, BLOCKS, WIDTH_IN)

  always_ff @(posedge Clk) begin
    if (Clear) begin
      en_bar_q <= '1;
      for (int b = 0; b < BLOCKS; b++) data_q[b] <= '0;
    end else begin
      en_bar_q <= Enable_bar;
      if (!Data_hold) begin
        for (int b = 0; b < BLOCKS; b++) data_q[b] <= a_word[b];
      end
    end
  end

  ttl_74356_sel_if #(.WIDTH_SELECT(WIDTH_SELECT)) sel_bus ();

  assign sel_bus.load   = Select_load;
  assign sel_bus.scan   = Scan;
  assign sel_bus.sel_in = Select;

  ttl_74356_select #(
    .WIDTH_IN     (WIDTH_IN),
    .WIDTH_SELECT (WIDTH_SELECT)
  ) u_select (
    .clk   (Clk),
    .clear (Clear),
    .bus   (sel_bus)
  );

  assign in_range = 32'(sel_bus.sel_cur) < WIDTH_IN;

  always_comb begin
    y_int = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      if (!en_bar_q[b] && in_range) y_int[b] = data_q[b][sel_bus.sel_cur];
    end
  end

  assign Y              = y_int;
  assign Y_bar          = ~y_int;
  assign Select_current = sel_bus.sel_cur;
  assign Wrap           = sel_bus.wrap;
endmodule

// File: tb/tb_ttl_74356.sv
// Directed bench for ttl_74356: default 8-input build plus a 5-input build.
// Drives both from shared controls and checks outputs 1ns after each edge.
module tb_ttl_74356;
  logic        clk = 1'b0;
  logic        clear;
  logic [1:0]  en_bar;
  logic        load;
  logic        scan;
  logic [2:0]  sel;
  logic        hold;
  logic [15:0] a;
  logic [9:0]  a2;

  logic [1:0]  y, y_bar, y2, y2_bar;
  logic [2:0]  selc, selc2;
  logic        wrap, wrap2;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] held;
  int          s_mod;

  always #5 clk = ~clk;

  ttl_74356 dut (
    .Clk(clk), .Clear(clear), .Enable_bar(en_bar),
    .Select_load(load), .Scan(scan), .Select(sel),
    .Data_hold(hold), .A_2D(a),
    .Y(y), .Y_bar(y_bar), .Select_current(selc), .Wrap(wrap)
  );

  ttl_74356 #(.BLOCKS(2), .WIDTH_IN(5), .WIDTH_SELECT(3)) dut5 (
    .Clk(clk), .Clear(clear), .Enable_bar(en_bar),
    .Select_load(load), .Scan(scan), .Select(sel),
    .Data_hold(hold), .A_2D(a2),
    .Y(y2), .Y_bar(y2_bar), .Select_current(selc2), .Wrap(wrap2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with random inputs
    clear = 1'b1; en_bar = 2'($urandom); load = 1'($urandom);
    scan = 1'($urandom); sel = 3'($urandom); hold = 1'($urandom);
    a = 16'($urandom); a2 = 10'($urandom);
    tick();
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_ybar", 32'(y_bar), 32'h3);
    chk("rst_sel", 32'(selc), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst5_y", 32'(y2), 32'h0);
    chk("rst5_ybar", 32'(y2_bar), 32'h3);
    chk("rst5_sel", 32'(selc2), 32'h0);
    chk("rst5_wrap", 32'(wrap2), 32'h0);

    // Load and select channel 3
    clear = 1'b0; a = 16'hA55A; a2 = 10'b10011_01101; en_bar = 2'b00;
    load = 1'b1; scan = 1'b0; sel = 3'd3; hold = 1'b0;
    tick();
    chk("ld3_y", 32'(y), 32'h1);
    chk("ld3_ybar", 32'(y_bar), 32'h2);
    chk("ld3_sel", 32'(selc), 32'h3);
    chk("ld3_y5", 32'(y2), 32'h1);

    // Load 6: in range for 8 inputs, out of range for 5
    sel = 3'd6;
    tick();
    chk("ld6_sel", 32'(selc), 32'h6);
    chk("ld6_y", 32'(y), 32'h1);
    chk("ld6_wrap", 32'(wrap), 32'h0);
    chk("ld6_sel5", 32'(selc2), 32'h6);
    chk("ld6_y5", 32'(y2), 32'h0);
    chk("ld6_ybar5", 32'(y2_bar), 32'h3);

    // Scan 7, 0, 1 (5-input build: 0, 1, 2)
    load = 1'b0; scan = 1'b1;
    tick();
    chk("sc1_sel", 32'(selc), 32'h7);
    chk("sc1_wrap", 32'(wrap), 32'h0);
    chk("sc1_y", 32'(y), 32'h2);
    chk("sc1_sel5", 32'(selc2), 32'h0);
    chk("sc1_wrap5", 32'(wrap2), 32'h1);
    chk("sc1_y5", 32'(y2), 32'h3);
    tick();
    chk("sc2_sel", 32'(selc), 32'h0);
    chk("sc2_wrap", 32'(wrap), 32'h1);
    chk("sc2_y", 32'(y), 32'h2);
    chk("sc2_sel5", 32'(selc2), 32'h1);
    chk("sc2_wrap5", 32'(wrap2), 32'h0);
    chk("sc2_y5", 32'(y2), 32'h2);
    tick();
    chk("sc3_sel", 32'(selc), 32'h1);
    chk("sc3_wrap", 32'(wrap), 32'h0);
    chk("sc3_y", 32'(y), 32'h1);
    chk("sc3_sel5", 32'(selc2), 32'h2);

    // Capture 3C96, then hold it while A_2D churns and scan everything
    held = 16'h3C96;
    scan = 1'b0; load = 1'b1; sel = 3'd0; a = held;
    tick();
    chk("cap_y", 32'(y), 32'h0);
    load = 1'b0; scan = 1'b1; hold = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      a = 16'($urandom);
      tick();
      s_mod = s % 8;
      chk("hold_sel", 32'(selc), 32'(s_mod));
      chk("hold_y", 32'(y), 32'({held[8 + s_mod], held[s_mod]}));
      chk("hold_wrap", 32'(wrap), 32'(s == 8));
    end

    // Channel 4 has both blocks set; then disable block 0
    scan = 1'b0; load = 1'b1; sel = 3'd4;
    tick();
    chk("h4_y", 32'(y), 32'h3);
    load = 1'b0; en_bar = 2'b01;
    tick();
    chk("en_y", 32'(y), 32'h2);
    chk("en_ybar", 32'(y_bar), 32'h1);

    // Load beats scan even at the wrap point
    en_bar = 2'b00; load = 1'b1; sel = 3'd7;
    tick();
    chk("p7_sel", 32'(selc), 32'h7);
    chk("p7_y", 32'(y), 32'h1);
    scan = 1'b1; sel = 3'd2;
    tick();
    chk("pri_sel", 32'(selc), 32'h2);
    chk("pri_wrap", 32'(wrap), 32'h0);
    chk("pri_y", 32'(y), 32'h3);
    chk("pri_sel5", 32'(selc2), 32'h2);
    chk("pri_wrap5", 32'(wrap2), 32'h0);

    // Clear beats load
    scan = 1'b0; clear = 1'b1; sel = 3'd5;
    tick();
    chk("clr_sel", 32'(selc), 32'h0);
    chk("clr_y", 32'(y), 32'h0);
    chk("clr_ybar", 32'(y_bar), 32'h3);
    chk("clr_wrap", 32'(wrap), 32'h0);

    // Clear aborts a scan at the wrap point with no pulse
    clear = 1'b0; load = 1'b1; sel = 3'd7;
    tick();
    chk("ab7_sel", 32'(selc), 32'h7);
    clear = 1'b1; load = 1'b0; scan = 1'b1;
    tick();
    chk("ab_sel", 32'(selc), 32'h0);
    chk("ab_wrap", 32'(wrap), 32'h0);
    chk("ab_wrap5", 32'(wrap2), 32'h0);
    clear = 1'b0; scan = 1'b0;
    tick();
    chk("ab_wrap_after", 32'(wrap), 32'h0);
    chk("ab_sel_after", 32'(selc), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
